// File: rtl/usb_rx_token_decoder_if.sv
// Destuffed-bit input and decoded-token result bundle between the RX bit path and token decoder.
// Latency: none (wiring only). No backpressure: bits and results are one-cycle strobes.
interface usb_rx_token_decoder_if;
    logic        sop;
    logic        bit_strobe;
    logic        bit_in;
    logic        eop;
    logic        busy;
    logic        token_valid;
    logic [3:0]  token_pid;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic [10:0] frame_num;
    logic        pid_err;
    logic        crc_err;
    logic        len_err;

    modport master (
        output sop, bit_strobe, bit_in, eop,
        input  busy, token_valid, token_pid, token_addr, token_endp, frame_num,
               pid_err, crc_err, len_err
    );

    modport slave (
        input  sop, bit_strobe, bit_in, eop,
        output busy, token_valid, token_pid, token_addr, token_endp, frame_num,
               pid_err, crc_err, len_err
    );
endinterface

// File: rtl/usb_rx_token_decoder.sv
// USB token decoder: PID check, CRC-5 over the 11-bit field, one result pulse per packet.
// Latency: result pulse one cycle after eop. No backpressure: the bit stream is never stalled.
module usb_rx_token_decoder #(
    parameter int         TOKEN_BITS = 24,
    parameter logic [4:0] CRC_SEED   = 5'b11111
) (
    input logic                   clk,
    input logic                   n_rst,
    usb_rx_token_decoder_if.slave rx
);
    typedef enum logic [2:0] {S_IDLE, S_PID, S_FIELD, S_CRC, S_CHECK, S_WAIT_EOP} state_t;

    localparam logic [4:0] PID_LAST   = 5'd7;
    localparam logic [4:0] FIELD_LAST = 5'd18;
    localparam logic [4:0] CRC_FIRST  = 5'd19;
    localparam logic [4:0] CRC_LAST   = 5'(TOKEN_BITS - 1);

    state_t      state, state_n;
    logic [4:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  pid_sr, pid_sr_n;
    logic [10:0] field_sr, field_sr_n;
    logic [4:0]  crc, crc_n;
    logic        crc_ok, crc_ok_n;
    logic        token_valid_n, pid_err_n, crc_err_n, len_err_n;
    logic        token_valid_q, pid_err_q, crc_err_q, len_err_q;
    logic [3:0]  token_pid_q, token_endp_q;
    logic [6:0]  token_addr_q;
    logic [10:0] frame_num_q;
    logic [2:0]  crc_idx;
    logic        fb;

    // Received CRC arrives MSb first, each bit the complement of the residue bit
    assign crc_idx = 3'd4 - 3'(bit_cnt - CRC_FIRST);
    assign fb      = crc[4] ^ rx.bit_in;

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        pid_sr_n      = pid_sr;
        field_sr_n    = field_sr;
        crc_n         = crc;
        crc_ok_n      = crc_ok;
        token_valid_n = 1'b0;
        pid_err_n     = 1'b0;
        crc_err_n     = 1'b0;
        len_err_n     = 1'b0;

        if (rx.sop) begin
            state_n   = S_PID;
            bit_cnt_n = '0;
            crc_n     = CRC_SEED;
            crc_ok_n  = 1'b1;
            if (rx.bit_strobe) begin
                pid_sr_n  = {rx.bit_in, pid_sr[7:1]};
                bit_cnt_n = 5'd1;
            end
        end else begin
            case (state)
                S_PID: if (rx.bit_strobe) begin
                    pid_sr_n  = {rx.bit_in, pid_sr[7:1]};
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == PID_LAST) begin
                        // Token PIDs are exactly those whose low two bits are 2'b01
                        if (pid_sr_n[7:4] != ~pid_sr_n[3:0]) begin
                            pid_err_n = 1'b1;
                            state_n   = S_WAIT_EOP;
                        end else if (pid_sr_n[1:0] == 2'b01) begin
                            state_n = S_FIELD;
                        end else begin
                            state_n = S_WAIT_EOP;
                        end
                    end
                end
                S_FIELD: if (rx.bit_strobe) begin
                    field_sr_n = {rx.bit_in, field_sr[10:1]};
                    crc_n      = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
                    bit_cnt_n  = bit_cnt + 5'd1;
                    if (bit_cnt == FIELD_LAST) state_n = S_CRC;
                end
                S_CRC: if (rx.bit_strobe) begin
                    if (rx.bit_in != ~crc[crc_idx]) crc_ok_n = 1'b0;
                    bit_cnt_n = bit_cnt + 5'd1;
                    if (bit_cnt == CRC_LAST) state_n = S_CHECK;
                end
                S_CHECK: if (rx.bit_strobe) begin
                    len_err_n = 1'b1;
                    state_n   = S_WAIT_EOP;
                end
                default: ;
            endcase

            // eop is judged against the state reached after any same-cycle bit
            if (rx.eop) begin
                case (state_n)
                    S_PID, S_FIELD, S_CRC: begin
                        len_err_n = 1'b1;
                        state_n   = S_IDLE;
                    end
                    S_CHECK: begin
                        token_valid_n = crc_ok_n;
                        crc_err_n     = ~crc_ok_n;
                        state_n       = S_IDLE;
                    end
                    S_WAIT_EOP: state_n = S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            pid_sr        <= '0;
            field_sr      <= '0;
            crc           <= CRC_SEED;
            crc_ok        <= 1'b0;
            token_valid_q <= 1'b0;
            pid_err_q     <= 1'b0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            token_pid_q   <= '0;
            token_addr_q  <= '0;
            token_endp_q  <= '0;
            frame_num_q   <= '0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            pid_sr        <= pid_sr_n;
            field_sr      <= field_sr_n;
            crc           <= crc_n;
            crc_ok        <= crc_ok_n;
            token_valid_q <= token_valid_n;
            pid_err_q     <= pid_err_n;
            crc_err_q     <= crc_err_n;
            len_err_q     <= len_err_n;
            if (token_valid_n) begin
                token_pid_q  <= pid_sr[3:0];
                token_addr_q <= field_sr[6:0];
                token_endp_q <= field_sr[10:7];
                frame_num_q  <= field_sr;
            end
        end
    end

    assign rx.busy        = (state != S_IDLE);
    assign rx.token_valid = token_valid_q;
    assign rx.pid_err     = pid_err_q;
    assign rx.crc_err     = crc_err_q;
    assign rx.len_err     = len_err_q;
    assign rx.token_pid   = token_pid_q;
    assign rx.token_addr  = token_addr_q;
    assign rx.token_endp  = token_endp_q;
    assign rx.frame_num   = frame_num_q;
endmodule

// File: tb/tb_usb_rx_token_decoder.sv
// Randomized and directed token packets scored against a packet-level reference model.
module tb_usb_rx_token_decoder;
    localparam logic [3:0] K_TV  = 4'b1000;
    localparam logic [3:0] K_PID = 4'b0100;
    localparam logic [3:0] K_CRC = 4'b0010;
    localparam logic [3:0] K_LEN = 4'b0001;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  kind;
        logic        bsy;
        logic [3:0]  pid;
        logic [10:0] field;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    usb_rx_token_decoder_if bus();
    usb_rx_token_decoder dut (.clk(clk), .n_rst(n_rst), .rx(bus));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [3:0]  m_pid = '0;
    logic [10:0] m_field = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [4:0] crc5(input logic [10:0] f);
        logic [4:0] c;
        logic       b;
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            b = c[4] ^ f[i];
            c = {c[3:0], 1'b0} ^ (b ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    function automatic logic [7:0] mkpid(input logic [3:0] p);
        return {~p, p};
    endfunction

    task automatic drive(input logic s, input logic b, input logic bi, input logic e);
        bus.sop = s; bus.bit_strobe = b; bus.bit_in = bi; bus.eop = e;
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] kind, input logic bsy);
        exp_t e;
        e.cyc = cyc + 1; e.kind = kind; e.bsy = bsy; e.pid = m_pid; e.field = m_field;
        q.push_back(e);
    endtask

    // trig: bit index that produces the pulse, -1 = the eop cycle, -2 = no pulse
    task automatic send(input logic [7:0] pid, input logic [10:0] fld, input logic [4:0] crcv,
                        input int nbits, input bit abort, input bit sop_bit, input bit eop_last);
        logic [31:0] bits;
        logic [3:0]  kind;
        int          trig;
        bit          pid_ok, is_tok, e;
        bits = $urandom();
        bits[7:0] = pid;
        bits[18:8] = fld;
        for (int k = 0; k < 5; k++) bits[19+k] = crcv[4-k];
        pid_ok = (pid[7:4] == ~pid[3:0]);
        is_tok = pid[3:0] inside {4'b0001, 4'b1001, 4'b0101, 4'b1101};
        kind = '0; trig = -2;
        if (nbits >= 8 && !pid_ok) begin kind = K_PID; trig = 7; end
        else if (nbits < 8)        begin kind = K_LEN; trig = -1; end
        else if (!is_tok)          begin kind = '0;    trig = -2; end
        else if (nbits < 24)       begin kind = K_LEN; trig = -1; end
        else if (nbits > 24)       begin kind = K_LEN; trig = 24; end
        else if (crcv == ~crc5(fld)) begin kind = K_TV; trig = -1; end
        else                       begin kind = K_CRC; trig = -1; end
        if (abort && trig == -1) trig = -2;
        if (kind == K_TV && trig == -1) begin m_pid = pid[3:0]; m_field = fld; end

        if (!sop_bit) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0 || !sop_bit)
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'($urandom()), 1'b0);
            e = eop_last && !abort && (i == nbits - 1);
            if (e) chk("busy_before_eop", bus.busy, 1);
            if (trig == i || (e && trig == -1)) push(kind, !e);
            drive(sop_bit && i == 0, 1'b1, bits[i], e);
        end
        if (!abort && !eop_last) begin
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk("busy_before_eop", bus.busy, 1);
            if (trig == -1) push(kind, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (!abort) chk("busy_after_eop", bus.busy, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every result pulse must match the head of the expectation queue
    initial begin
        exp_t       e;
        logic [3:0] got;
        forever begin
            @(negedge clk);
            got = {bus.token_valid, bus.pid_err, bus.crc_err, bus.len_err};
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("pulse_kind", got, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
                chk("busy_at_pulse", bus.busy, e.bsy);
                chk("token_pid", bus.token_pid, e.pid);
                if (e.pid == 4'b0101) chk("frame_num", bus.frame_num, e.field);
                else begin
                    chk("token_addr", bus.token_addr, e.field[6:0]);
                    chk("token_endp", bus.token_endp, e.field[10:7]);
                end
            end else if (got != 4'b0000) begin
                chk("unexpected_pulse", got, 0);
            end
        end
    end

    initial begin
        logic [10:0] f_setup, f_sof, f;
        logic [7:0]  p, p_setup;
        logic [4:0]  c;
        int          r;
        f_setup = {4'hE, 7'h15};
        p_setup = mkpid(4'b1101);
        f_sof   = 11'h710;

        bus.sop = 1'b0; bus.bit_strobe = 1'b0; bus.bit_in = 1'b0; bus.eop = 1'b0;
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_pulses", {bus.token_valid, bus.pid_err, bus.crc_err, bus.len_err}, 0);
        chk("reset_fields", {bus.token_pid, bus.token_addr, bus.token_endp, bus.frame_num}, 0);

        send(p_setup, f_setup, 5'b10111, 24, 0, 0, 0);

        // reset while the field is being shifted in
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            drive(1'b0, 1'b1, (i < 8) ? p_setup[i] : f_setup[i-8], 1'b0);
        chk("busy_mid_field", bus.busy, 1);
        n_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        m_pid = '0; m_field = '0;
        chk("busy_after_reset", bus.busy, 0);
        chk("addr_after_reset", bus.token_addr, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        send(p_setup, f_setup, 5'b10111, 24, 0, 0, 0);
        send(p_setup, f_setup, 5'b10011, 24, 0, 1, 1);
        send(8'b0000_1001, f_setup, 5'b10111, 24, 0, 0, 0);
        send(p_setup, f_setup, 5'b10111, 20, 0, 0, 0);
        send(p_setup, f_setup, 5'b10111, 25, 0, 0, 0);
        send(8'b1100_0011, f_setup, 5'b10111, 24, 0, 0, 0);
        send(mkpid(4'b0001), 11'h2A5, ~crc5(11'h2A5), 12, 1, 0, 0);
        send(mkpid(4'b0101), f_sof, ~crc5(f_sof), 24, 0, 0, 1);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: p = mkpid(4'b0001);
                1: p = mkpid(4'b1001);
                2: p = mkpid(4'b0101);
                3: p = mkpid(4'b1101);
                4: p = 8'b1100_0011;
                default: p = 8'($urandom());
            endcase
            f = 11'($urandom());
            c = ~crc5(f);
            if ($urandom_range(0, 3) == 0) c = c ^ (5'b00001 << $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0)
                send(p, f, c, $urandom_range(1, 23), 1, 1'($urandom()), 0);
            else if ($urandom_range(0, 9) < 7)
                send(p, f, c, 24, 0, 1'($urandom()), 1'($urandom()));
            else
                send(p, f, c, $urandom_range(5, 27), 0, 1'($urandom()), 1'($urandom()));
            repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0);
        end

        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
